// File: rtl/theta_pipe_stage.sv
// Two-register Keccak theta stage: column parity is registered first, then the
// D-mix and lane XOR are registered in front of the rho consumer.
package keccak_pkg;
    localparam int ROW_SIZE  = 5;
    localparam int COL_SIZE  = 5;
    localparam int LANE_SIZE = 64;
endpackage

module theta_pipe_stage
    import keccak_pkg::*;
(
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic                                             valid_i,
    output logic                                             ready_o,
    input  logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_i,
    output logic                                             valid_o,
    input  logic                                             ready_i,
    output logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] state_array_o
);

    logic                                             s1_valid;
    logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] s1_state;
    logic [ROW_SIZE-1:0][LANE_SIZE-1:0]               s1_parity;
    logic [ROW_SIZE-1:0][LANE_SIZE-1:0]               parity;
    logic [ROW_SIZE-1:0][LANE_SIZE-1:0]               d_mix;
    logic [ROW_SIZE-1:0][COL_SIZE-1:0][LANE_SIZE-1:0] theta;
    logic                                             s1_advance;
    logic                                             s2_advance;
    logic                                             in_xfer;

    // Each stage refills whenever it is empty or its successor is draining.
    assign s2_advance = !valid_o || ready_i;
    assign s1_advance = !s1_valid || s2_advance;
    assign ready_o    = s1_advance && !rst;
    assign in_xfer    = valid_i && ready_o;

    always_comb begin
        parity = '0;
        for (int x = 0; x < ROW_SIZE; x++)
            for (int y = 0; y < COL_SIZE; y++)
                parity[x] = parity[x] ^ state_array_i[x][y];
    end

    for (genvar x = 0; x < ROW_SIZE; x++) begin : g_col
        localparam int XM = (x + ROW_SIZE - 1) % ROW_SIZE;
        localparam int XP = (x + 1) % ROW_SIZE;
        assign d_mix[x] = s1_parity[XM] ^ {s1_parity[XP][LANE_SIZE-2:0], s1_parity[XP][LANE_SIZE-1]};
        for (genvar y = 0; y < COL_SIZE; y++) begin : g_row
            assign theta[x][y] = s1_state[x][y] ^ d_mix[x];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_state      <= '0;
            s1_parity     <= '0;
            valid_o       <= 1'b0;
            state_array_o <= '0;
        end else begin
            if (s1_advance)
                s1_valid <= in_xfer;
            if (in_xfer) begin
                s1_state  <= state_array_i;
                s1_parity <= parity;
            end
            if (s2_advance) begin
                valid_o       <= s1_valid;
                state_array_o <= theta;
            end
        end
    end

endmodule
